// File: rtl/dice_mask_pkg.sv
// Shared types and helpers for the mask lane distributor.
// Holds the unroll-code type, the sequencing FSM state type, the largest
// supported lane count and the slice-geometry functions used by the permute.
package dice_mask_pkg;

   localparam int MAX_LANES = 16;

   // Wide enough for clog2(MAX_LANES)+1, the widest unroll code port.
   typedef logic [4:0] unroll_code_t;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_SEQ  = 1'b1
   } seq_state_t;

   // Width of one interleaved slice for unroll code k.
   function automatic int slice_w(input int lane_w, input int k);
      return lane_w >> (k + 32'sd1);
   endfunction

   // Source bit in the chunk feeding bit bit_idx of lane `lane` under code k.
   // With k=0 this degenerates to lane*lane_w + bit_idx (plain split).
   function automatic int src_bit(input int lane_w, input int k, input int lane, input int bit_idx);
      int s;
      int u;
      s = slice_w(lane_w, k);
      u = 32'sd1 << k;
      return ((lane >> k) * u * lane_w) + ((bit_idx / s) * u * s) + ((lane % u) * s) + (bit_idx % s);
   endfunction

endpackage

// File: rtl/mask_lane_permute.sv
// Combinational chunk-to-lane mask permutation.
// Every legal unroll code gets its own fixed wiring pattern; the code only
// selects between them, so the permute is pure routing plus one mux level.
module mask_lane_permute
   import dice_mask_pkg::*;
#(
   parameter int NUM_LANES = 4,
   parameter int LANE_W    = 64
) (
   input  logic [NUM_LANES*LANE_W-1:0] in_mask,
   input  unroll_code_t                code,
   output logic [NUM_LANES*LANE_W-1:0] lane_mask,
   output logic [NUM_LANES-1:0]        lane_any
);

   localparam int CHUNK_W = NUM_LANES * LANE_W;
   localparam int MAX_K   = $clog2(NUM_LANES);

   logic [MAX_K:0][CHUNK_W-1:0] perm_s;

   for (genvar k = 0; k <= MAX_K; k++) begin : g_code
      for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
         for (genvar b = 0; b < LANE_W; b++) begin : g_bit
            localparam int SRC = src_bit(LANE_W, k, l, b);
            assign perm_s[k][l*LANE_W+b] = in_mask[SRC];
         end
      end
   end

   // Select the wiring pattern for the (already legalised) unroll code.
   always_comb begin
      lane_mask = perm_s[0];
      for (int k = 1; k <= MAX_K; k++) begin
         if (code == unroll_code_t'(k)) begin
            lane_mask = perm_s[k];
         end else begin
         end
      end
   end

   // Per-lane activity summary.
   always_comb begin
      lane_any = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
         lane_any[l] = |lane_mask[l*LANE_W +: LANE_W];
      end
   end

endmodule

// File: rtl/mask_lane_distributor.sv
// Mask lane distributor top: sequence FSM, chunk counter, 2-entry output FIFO.
// Optional build macro MASK_SKIP_EMPTY_EN: all-zero non-last chunks are
// consumed (counter still advances) without producing an output entry.
module mask_lane_distributor
   import dice_mask_pkg::*;
#(
   parameter int NUM_LANES = 4,
   parameter int LANE_W    = 64,
   parameter int CIDX_W    = 4,
   localparam int CHUNK_W  = NUM_LANES * LANE_W,
   localparam int UL_W     = $clog2(NUM_LANES) + 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [CHUNK_W-1:0]   in_mask,
   input  logic [UL_W-1:0]      in_unroll_log2,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [CHUNK_W-1:0]   out_mask,
   output logic [NUM_LANES-1:0] out_lane_any,
   output logic [CIDX_W-1:0]    out_chunk_idx,
   output logic                 out_last,
   output logic                 err_unroll
);

   localparam int MAX_K   = $clog2(NUM_LANES);
   localparam int ENTRY_W = CHUNK_W + NUM_LANES + CIDX_W + 1;

   seq_state_t          state_r;
   unroll_code_t        unroll_r;
   logic [CIDX_W-1:0]   cnt_r;
   logic                err_r;
   logic [1:0]          count_r;
   logic [ENTRY_W-1:0]  head_r;
   logic [ENTRY_W-1:0]  tail_r;

   logic                accept_s;
   logic                push_s;
   logic                pop_s;
   logic                skip_s;
   logic                illegal_s;
   unroll_code_t        code_in_s;
   unroll_code_t        legal_code_s;
   unroll_code_t        eff_code_s;
   logic [CHUNK_W-1:0]  perm_mask_s;
   logic [NUM_LANES-1:0] perm_any_s;
   logic [ENTRY_W-1:0]  new_entry_s;

   assign in_ready  = (count_r < 2'd2);
   assign out_valid = (count_r != 2'd0);
   assign accept_s  = in_valid && in_ready;
   assign pop_s     = out_valid && out_ready;

   assign code_in_s    = unroll_code_t'(in_unroll_log2);
   assign illegal_s    = (code_in_s > unroll_code_t'(MAX_K));
   assign legal_code_s = illegal_s ? unroll_code_t'(0) : code_in_s;
   // Inside a sequence the input code is ignored in favour of the latched one.
   assign eff_code_s   = (state_r == S_IDLE) ? legal_code_s : unroll_r;

`ifdef MASK_SKIP_EMPTY_EN
   assign skip_s = (in_mask == '0) && !in_last;
`else
   assign skip_s = 1'b0;
`endif

   assign push_s = accept_s && !skip_s;

   mask_lane_permute #(
      .NUM_LANES (NUM_LANES),
      .LANE_W    (LANE_W)
   ) u_permute (
      .in_mask   (in_mask),
      .code      (eff_code_s),
      .lane_mask (perm_mask_s),
      .lane_any  (perm_any_s)
   );

   assign new_entry_s = {perm_mask_s, perm_any_s, cnt_r, in_last};

   assign out_mask      = head_r[ENTRY_W-1 -: CHUNK_W];
   assign out_lane_any  = head_r[CIDX_W+1 +: NUM_LANES];
   assign out_chunk_idx = head_r[1 +: CIDX_W];
   assign out_last      = head_r[0];
   assign err_unroll    = err_r;

   // Sequence FSM: latches the unroll code at sequence start, flags illegal codes.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= S_IDLE;
         unroll_r <= unroll_code_t'(0);
         err_r    <= 1'b0;
      end else if (accept_s) begin
         case (state_r)
            S_IDLE: begin
               unroll_r <= legal_code_s;
               if (illegal_s) begin
                  err_r <= 1'b1;
               end
               state_r <= in_last ? S_IDLE : S_SEQ;
            end
            S_SEQ: begin
               state_r <= in_last ? S_IDLE : S_SEQ;
            end
            default: begin
               state_r <= S_IDLE;
            end
         endcase
      end
   end

   // Chunk index counter: restarts after the last chunk of a sequence.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r <= '0;
      end else if (accept_s) begin
         cnt_r <= in_last ? '0 : cnt_r + CIDX_W'(1);
      end
   end

   // Two-entry output FIFO: head_r drives the outputs, tail_r holds the spare.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_r <= 2'd0;
         head_r  <= '0;
         tail_r  <= '0;
      end else begin
         case ({push_s, pop_s})
            2'b10: begin
               if (count_r == 2'd0) begin
                  head_r <= new_entry_s;
               end else begin
                  tail_r <= new_entry_s;
               end
               count_r <= count_r + 2'd1;
            end
            2'b01: begin
               head_r  <= tail_r;
               count_r <= count_r - 2'd1;
            end
            2'b11: begin
               if (count_r == 2'd1) begin
                  head_r <= new_entry_s;
               end else begin
                  head_r <= tail_r;
                  tail_r <= new_entry_s;
               end
            end
            default: begin
               count_r <= count_r;
            end
         endcase
      end
   end

endmodule

// File: doc/mask_lane_distributor.md
MASK_LANE_DISTRIBUTOR -- requirements
Module: mask_lane_distributor

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4, lane count (power of two, 1..16).
REQ-002 SHALL have parameter LANE_W, default 64, per-lane mask bits (power of two, >= 2*NUM_LANES).
REQ-003 SHALL have parameter CIDX_W, default 4, chunk-index counter width.
REQ-004 SHALL have localparam CHUNK_W = NUM_LANES*LANE_W and UL_W = clog2(NUM_LANES)+1.
REQ-005 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high.
REQ-007 SHALL have port in_valid  input  1  chunk offered.
REQ-008 SHALL have port in_ready  output  1  chunk accepted when in_valid && in_ready.
REQ-009 SHALL have port in_mask  input  CHUNK_W  active-mask chunk.
REQ-010 SHALL have port in_unroll_log2  input  UL_W  unroll factor U = 2^in_unroll_log2.
REQ-011 SHALL have port in_last  input  1  final chunk of a sequence.
REQ-012 SHALL have port out_valid  output  1  lane masks available.
REQ-013 SHALL have port out_ready  input  1  consumer takes the output entry.
REQ-014 SHALL have port out_mask  output  NUM_LANES*LANE_W  lane l at bits [l*LANE_W +: LANE_W].
REQ-015 SHALL have port out_lane_any  output  NUM_LANES  OR-reduce of each lane mask.
REQ-016 SHALL have port out_chunk_idx  output  CIDX_W  index of chunk within sequence.
REQ-017 SHALL have port out_last  output  1  copy of in_last of emitted chunk.
REQ-018 SHALL have port err_unroll  output  1  sticky illegal-unroll flag.

Function
REQ-019 SHALL map, for latched code k: k=0 lane l = in_mask[l*LANE_W +: LANE_W]; k>=1 slice S = LANE_W>>(k+1), group g = l>>k holds U*LANE_W bits at g*U*LANE_W, lane l takes slice j (j=0..LANE_W/S-1) from group offset j*U*S + (l mod U)*S.
REQ-020 SHALL treat code k > log2(NUM_LANES) as k=0 and set err_unroll on that accept.
REQ-021 SHALL run FSM S_IDLE/S_SEQ: unroll latched on accept in S_IDLE; S_IDLE->S_SEQ on accept with in_last=0; S_SEQ->S_IDLE on accept with in_last=1; last accept in S_IDLE stays S_IDLE.
REQ-022 SHALL ignore in_unroll_log2 while in S_SEQ (latched value used).
REQ-023 SHALL assign out_chunk_idx from counter reset to 0 on last accept, +1 otherwise, wrapping at 2^CIDX_W.
REQ-024 SHALL buffer emitted entries in a 2-entry FIFO; in_ready = (count < 2), registered-count only, independent of out_ready.
REQ-025 SHALL present an accepted chunk on out_* the cycle after acceptance (1-cycle latency) when FIFO was empty.
REQ-026 SHALL hold out_* stable while out_valid && !out_ready.
REQ-027 SHALL support simultaneous push and pop at count 1 with count unchanged and order preserved.

Reset
REQ-028 SHALL on reset clear: FSM to S_IDLE, FIFO count 0, out_valid 0, in_ready 1 next cycle, chunk counter 0, latched unroll 0, err_unroll 0, out_mask/out_lane_any/out_chunk_idx/out_last 0.
REQ-029 SHALL discard any open sequence and buffered entries on reset mid-operation; no partial output afterwards.

Configuration
REQ-030 SHALL, with MASK_SKIP_EMPTY_EN defined, consume an all-zero non-last chunk without emitting it while still advancing the chunk counter; all-zero last chunks are emitted.
REQ-031 SHALL, without MASK_SKIP_EMPTY_EN, emit every accepted chunk.

Structure
REQ-032 SHALL place unroll-code typedef, max-lane constant and slice-width function in package dice_mask_pkg.
REQ-033 SHALL implement REQ-019 mapping in combinational sub-module mask_lane_permute; FSM, counter, FIFO in top.

Verification
REQ-034 SHALL check k=0, in_mask bit 70 set, last=1 -> next cycle out_mask bit 70 (lane1 bit 6), out_lane_any=4'b0010, out_chunk_idx=0.
REQ-035 SHALL check k=1, in_mask bit 16 set -> lane1 bit 0; k=2, bit 40 -> lane1 bit 8.
REQ-036 SHALL check 3-chunk sequence k=2 then k=0 on chunks 2-3 -> all use k=2, idx 0,1,2, FSM back to S_IDLE.
REQ-037 SHALL check out_ready=0 for 3 accepts -> in_ready=0 after 2, entries drain in order once out_ready=1.
REQ-038 SHALL check k=5 (NUM_LANES=4) -> mapped as k=0, err_unroll=1 until reset.
REQ-039 SHALL check MASK_SKIP_EMPTY_EN: chunks zero,nonzero(last) -> one output, out_chunk_idx=1; reset mid-sequence -> out_valid=0, next idx=0.
